// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared branch-condition codes, branch FSM states and default PC width.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int PC_W_DEF = 10;

  typedef enum logic [2:0] {
    COND_JMP   = 3'b000,
    COND_JE    = 3'b001,
    COND_JA    = 3'b010,
    COND_JB    = 3'b011,
    COND_JAE   = 3'b100,
    COND_JBE   = 3'b101,
    COND_JNE   = 3'b110,
    COND_NEVER = 3'b111
  } br_cond_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_FLUSH   = 2'd2
  } br_state_e;

  // Flag vector layout is {above, equal, below}
  localparam int FLAG_A = 2;
  localparam int FLAG_E = 1;
  localparam int FLAG_B = 0;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond_eval.sv
// ============================================================================
//  Module   : branch_cond_eval
//  Brief    : Combinational decode of a branch condition against {above,equal,below}.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       take_o
);

  logic w_a, w_e, w_b;

  assign w_a = flags_i[FLAG_A];
  assign w_e = flags_i[FLAG_E];
  assign w_b = flags_i[FLAG_B];

  always_comb begin
    take_o = 1'b0;
    case (cond_i)
      COND_JMP:   take_o = 1'b1;
      COND_JE:    take_o = w_e;
      COND_JA:    take_o = w_a;
      COND_JB:    take_o = w_b;
      COND_JAE:   take_o = w_a | w_e;
      COND_JBE:   take_o = w_b | w_e;
      COND_JNE:   take_o = ~w_e;
      default:    take_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ============================================================================
//  Module   : branch_ctrl
//  Brief    : PC sequencer with flag register, branch resolve and flush pulse.
//             Macro FLAG_BYPASS_EN lets a same-cycle compare feed RESOLVE.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmp_valid,
  input  logic            above,
  input  logic            equal,
  input  logic            below,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  output logic            br_ready,
  input  logic            pc_en,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      flags,
  output logic            taken,
  output logic            flush,
  output logic            flag_err
);

  br_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [2:0]      cond_q, cond_d;
  logic [2:0]      flags_q, flags_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [2:0]      w_cmp_flags;
  logic            w_cmp_ok;
  logic [2:0]      w_eval_flags;
  logic            w_take;

  assign w_cmp_flags = {above, equal, below};
  assign w_cmp_ok    = cmp_valid && is_onehot3(w_cmp_flags);

`ifdef FLAG_BYPASS_EN
  assign w_eval_flags = w_cmp_ok ? w_cmp_flags : flags_q;
`else
  assign w_eval_flags = flags_q;
`endif

  branch_cond_eval u_cond_eval (
    .cond_i  (cond_q),
    .flags_i (w_eval_flags),
    .take_o  (w_take)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    cond_d   = cond_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    br_ready = 1'b0;
    taken    = 1'b0;
    flush    = 1'b0;

    // Flag capture runs independently of the branch FSM
    if (cmp_valid) begin
      if (w_cmp_ok) flags_d = w_cmp_flags;
      else          err_d   = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        br_ready = 1'b1;
        if (pc_en) pc_d = pc_q + PC_W'(1);
        if (br_valid) begin
          cond_d   = br_cond;
          target_d = br_target;
          state_d  = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (w_take) begin
          pc_d    = target_q;
          taken   = 1'b1;
          cnt_d   = 3'(FLUSH_CYCLES);
          state_d = ST_FLUSH;
        end else begin
          if (pc_en) pc_d = pc_q + PC_W'(1);
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      target_q <= '0;
      cond_q   <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      cond_q   <= cond_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign pc       = pc_q;
  assign flags    = flags_q;
  assign flag_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
//  Module   : tb_branch_ctrl
//  Brief    : Directed plus randomized self-checking bench for branch_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_ctrl;

  localparam int PC_W = 10;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            reset, cmp_valid, above, equal, below, br_valid, pc_en;
  logic [2:0]      br_cond;
  logic [PC_W-1:0] br_target;
  logic            br_ready, taken, flush, flag_err;
  logic [PC_W-1:0] pc;
  logic [2:0]      flags;

  int checks = 0;
  int errors = 0;

  // Reference model: a pending request, remaining flush cycles, and registers
  int       m_pc;
  logic [2:0] m_flags;
  bit       m_err;
  bit       m_pending;
  int       m_flush_left;
  logic [2:0] m_cond;
  int       m_target;

  branch_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(FC)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmp_valid (cmp_valid),
    .above     (above),
    .equal     (equal),
    .below     (below),
    .br_valid  (br_valid),
    .br_cond   (br_cond),
    .br_target (br_target),
    .br_ready  (br_ready),
    .pc_en     (pc_en),
    .pc        (pc),
    .flags     (flags),
    .taken     (taken),
    .flush     (flush),
    .flag_err  (flag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit a, e, b;
    a = f[2]; e = f[1]; b = f[0];
    case (c)
      3'd0: return 1'b1;
      3'd1: return e;
      3'd2: return a;
      3'd3: return b;
      3'd4: return a | e;
      3'd5: return b | e;
      3'd6: return !e;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] resolve_flags();
`ifdef FLAG_BYPASS_EN
    if (cmp_valid && $countones({above, equal, below}) == 1)
      return {above, equal, below};
`endif
    return m_flags;
  endfunction

  function automatic bit model_idle();
    return !m_pending && (m_flush_left == 0);
  endfunction

  task automatic model_update();
    bit t;
    if (reset) begin
      m_pc = 0; m_flags = 3'b000; m_err = 0;
      m_pending = 0; m_flush_left = 0;
      return;
    end
    t = m_pending && cond_true(m_cond, resolve_flags());
    if (cmp_valid) begin
      if ($countones({above, equal, below}) == 1) m_flags = {above, equal, below};
      else m_err = 1;
    end
    if (m_pending) begin
      if (t) begin
        m_pc = m_target;
        m_flush_left = FC;
      end else if (pc_en) begin
        m_pc = (m_pc + 1) % (1 << PC_W);
      end
      m_pending = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else begin
      if (pc_en) m_pc = (m_pc + 1) % (1 << PC_W);
      if (br_valid) begin
        m_pending = 1;
        m_cond    = br_cond;
        m_target  = int'(br_target);
      end
    end
  endtask

  // Compare outputs mid-cycle, then clock the DUT and the model together
  task automatic step();
    @(negedge clk);
    chk("pc",       32'(pc),       32'(m_pc));
    chk("flags",    32'(flags),    32'(m_flags));
    chk("flag_err", 32'(flag_err), 32'(m_err));
    chk("br_ready", 32'(br_ready), 32'(model_idle()));
    chk("taken",    32'(taken),    32'(m_pending && cond_true(m_cond, resolve_flags())));
    chk("flush",    32'(flush),    32'(m_flush_left > 0));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    reset = 0; cmp_valid = 0; above = 0; equal = 0; below = 0;
    br_valid = 0; br_cond = 3'd0; br_target = '0; pc_en = 0;
  endtask

  task automatic cmp(input logic [2:0] f);
    cmp_valid = 1; {above, equal, below} = f;
    step();
    cmp_valid = 0; {above, equal, below} = 3'b000;
  endtask

  task automatic request(input logic [2:0] c, input logic [PC_W-1:0] tgt);
    br_valid = 1; br_cond = c; br_target = tgt;
    step();
    br_valid = 0;
  endtask

  initial begin
    m_pc = 0; m_flags = 0; m_err = 0; m_pending = 0; m_flush_left = 0;
    m_cond = 0; m_target = 0;
    quiet();

    reset = 1;
    @(posedge clk); model_update(); #1;
    step();
    reset = 0;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ready", 32'(br_ready), 32'd1);

    // PC counting and wrap
    pc_en = 1;
    repeat (5) step();
    chk("pc_after5", 32'(pc), 32'd5);
    repeat (1018) step();
    chk("pc_max", 32'(pc), 32'd1023);
    step();
    chk("pc_wrap", 32'(pc), 32'd0);
    pc_en = 0;

    // Taken JE with a two-cycle flush
    cmp(3'b010);
    request(3'd1, 10'h155);
    chk("je_ready_resolve", 32'(br_ready), 32'd0);
    step();
    chk("je_pc", 32'(pc), 32'h155);
    chk("je_flush1", 32'(flush), 32'd1);
    step();
    chk("je_flush2", 32'(flush), 32'd1);
    step();
    chk("je_flush_done", 32'(flush), 32'd0);
    chk("je_idle", 32'(br_ready), 32'd1);

    // Not-taken JB with pc_en
    cmp(3'b100);
    pc_en = 1;
    request(3'd3, 10'h020);
    step();
    chk("jb_pc", 32'(pc), 32'h157);
    chk("jb_idle", 32'(br_ready), 32'd1);
    chk("jb_flush", 32'(flush), 32'd0);
    pc_en = 0;

    // Non-one-hot compare sets a sticky error
    cmp(3'b110);
    chk("err_set", 32'(flag_err), 32'd1);
    chk("err_flags", 32'(flags), 32'b100);
    repeat (3) step();
    chk("err_hold", 32'(flag_err), 32'd1);
    reset = 1; step(); reset = 0;
    chk("err_clr", 32'(flag_err), 32'd0);

    // Same-cycle compare during RESOLVE
    cmp(3'b001);
    request(3'd2, 10'h2AA);
    cmp(3'b100);
`ifdef FLAG_BYPASS_EN
    chk("bypass_pc", 32'(pc), 32'h2AA);
`else
    chk("bypass_pc", 32'(pc), 32'd0);
`endif
    repeat (3) step();

    // Reset in the first flush cycle abandons the redirect
    request(3'd0, 10'h3FF);
    step();
    chk("jmp_pc", 32'(pc), 32'h3FF);
    reset = 1; step(); reset = 0;
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_flush", 32'(flush), 32'd0);
    chk("abort_ready", 32'(br_ready), 32'd1);
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      cmp_valid = ($urandom_range(0, 2) == 0);
      {above, equal, below} = 3'($urandom_range(0, 7));
      br_valid  = $urandom_range(0, 1) == 1;
      br_cond   = 3'($urandom_range(0, 7));
      br_target = PC_W'($urandom);
      pc_en     = $urandom_range(0, 1) == 1;
      step();
    end
    quiet();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
